// File: rtl/multi_timer_control.sv
// N-channel egg-timer controller: one control FSM per countdown channel, shared user
// controls routed by ch_sel, selected channel's bargraph/alarm multiplexed onto the LEDs.
module multi_timer_control #(
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned CH_W         = 2,
   parameter int unsigned LED_W        = 8,
   parameter int unsigned ALARM_BLINKS = 16,
   parameter int unsigned AUTO_RELOAD  = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [CH_W-1:0]         ch_sel,
   input  logic                    cooktime_req,
   input  logic                    start_req,
   input  logic                    pause_req,
   input  logic                    seconds_req,
   input  logic                    minutes_req,
   input  logic                    timer_en,
   input  logic                    blink_pulse,
   input  logic [NUM_CH-1:0]       timer_done,
   input  logic [NUM_CH*LED_W-1:0] bargraph,
   output logic                    increment_seconds,
   output logic                    increment_minutes,
   output logic [NUM_CH-1:0]       prog_mode,
   output logic [NUM_CH-1:0]       run_enable,
   output logic [NUM_CH-1:0]       load_timer,
   output logic [LED_W-1:0]        output_leds,
   output logic                    timer_enabled_led,
   output logic                    timer_on_led,
   output logic                    any_done
);

   localparam int unsigned CNT_W = (ALARM_BLINKS > 1) ? $clog2(ALARM_BLINKS + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ALARM_BLINKS == 0) ? 0 : ALARM_BLINKS - 1);
   localparam bit RELOAD_EN = (AUTO_RELOAD != 0) && (ALARM_BLINKS != 0);

   typedef enum logic [2:0] {StIdle, StProg, StLoad, StRun, StPause, StDone} state_e;

   state_e           state_q     [NUM_CH];
   state_e           state_d     [NUM_CH];
   logic [CNT_W-1:0] alarm_cnt_q [NUM_CH];
   logic [CNT_W-1:0] alarm_cnt_d [NUM_CH];
   logic             flash_q, flash_d;
   logic [NUM_CH-1:0] sel;
   logic             sel_prog;

   // An out-of-range ch_sel matches no channel, so it selects nothing.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sel[i] = (ch_sel == CH_W'(i));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flash_q <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i]     <= StIdle;
            alarm_cnt_q[i] <= '0;
         end
      end else begin
         flash_q <= flash_d;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i]     <= state_d[i];
            alarm_cnt_q[i] <= alarm_cnt_d[i];
         end
      end
   end

   always_comb begin
      flash_d = flash_q ^ blink_pulse;
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i]     = state_q[i];
         // Held at zero outside DONE, which clears it on every entry.
         alarm_cnt_d[i] = '0;
         case (state_q[i])
            StIdle: begin
               if (sel[i] && cooktime_req)   state_d[i] = StProg;
               else if (sel[i] && start_req) state_d[i] = StLoad;
            end
            StProg: begin
               if (sel[i] && start_req && !cooktime_req) state_d[i] = StLoad;
            end
            StLoad: state_d[i] = StRun;
            StRun: begin
               if (sel[i] && cooktime_req)   state_d[i] = StProg;
               else if (timer_done[i])       state_d[i] = StDone;
               else if (sel[i] && pause_req) state_d[i] = StPause;
            end
            StPause: begin
               if (sel[i] && cooktime_req)                   state_d[i] = StProg;
               else if (sel[i] && (pause_req || start_req))  state_d[i] = StRun;
            end
            StDone: begin
               if (blink_pulse && (alarm_cnt_q[i] != '1)) begin
                  alarm_cnt_d[i] = alarm_cnt_q[i] + 1'b1;
               end else begin
                  alarm_cnt_d[i] = alarm_cnt_q[i];
               end
               if (sel[i] && cooktime_req)   state_d[i] = StProg;
               else if (sel[i] && start_req) state_d[i] = StLoad;
               else if (RELOAD_EN && blink_pulse && (alarm_cnt_q[i] == CNT_LAST)) begin
                  state_d[i] = StLoad;
               end
            end
            default: state_d[i] = StIdle;
         endcase
      end
   end

   always_comb begin
      prog_mode         = '0;
      run_enable        = '0;
      load_timer        = '0;
      output_leds       = '0;
      any_done          = 1'b0;
      timer_enabled_led = 1'b0;
      sel_prog          = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         prog_mode[i]  = (state_q[i] == StProg);
         run_enable[i] = (state_q[i] == StRun) && timer_en;
         load_timer[i] = (state_q[i] == StLoad);
         any_done      = any_done | (state_q[i] == StDone);
         if (sel[i]) begin
            sel_prog          = prog_mode[i];
            timer_enabled_led = run_enable[i];
            case (state_q[i])
               StRun:   output_leds = bargraph[i*LED_W +: LED_W];
               StPause: output_leds = bargraph[i*LED_W +: LED_W] & {LED_W{flash_q}};
               StDone:  output_leds = {LED_W{flash_q}};
               default: output_leds = '0;
            endcase
         end
      end
      increment_seconds = seconds_req & cooktime_req & sel_prog;
      increment_minutes = minutes_req & cooktime_req & sel_prog;
      timer_on_led      = timer_enabled_led & flash_q;
   end

endmodule

// File: tb/tb_multi_timer_control.sv
// Bench for multi_timer_control: three parameterisations share one stimulus stream and
// are checked every cycle against a per-channel behavioural model.
module tb_multi_timer_control;

   localparam int NI = 3;
   localparam int M_IDLE = 0, M_PROG = 1, M_LOAD = 2, M_RUN = 3, M_PAUSE = 4, M_DONE = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  ch_sel;
   logic        cooktime_req, start_req, pause_req, seconds_req, minutes_req;
   logic        timer_en, blink_pulse;
   logic [3:0]  timer_done;
   logic [31:0] bargraph;

   logic       a_is, a_im, a_tel, a_tol, a_ad;
   logic [3:0] a_pm, a_re, a_lt;
   logic [7:0] a_leds;
   logic       b_is, b_im, b_tel, b_tol, b_ad;
   logic [3:0] b_pm, b_re, b_lt;
   logic [7:0] b_leds;
   logic       c_is, c_im, c_tel, c_tol, c_ad;
   logic [2:0] c_pm, c_re, c_lt;
   logic [7:0] c_leds;

   int compared   = 0;
   int mismatched = 0;

   int m_st  [NI][4];
   int m_rem [NI][4];
   bit m_flash;

   logic [7:0] l1, l2;

   always #5 clk = ~clk;

   multi_timer_control #(.NUM_CH(4), .CH_W(2), .LED_W(8), .ALARM_BLINKS(16), .AUTO_RELOAD(0))
   dut_a (
      .clk(clk), .reset(reset), .ch_sel(ch_sel), .cooktime_req(cooktime_req),
      .start_req(start_req), .pause_req(pause_req), .seconds_req(seconds_req),
      .minutes_req(minutes_req), .timer_en(timer_en), .blink_pulse(blink_pulse),
      .timer_done(timer_done), .bargraph(bargraph), .increment_seconds(a_is),
      .increment_minutes(a_im), .prog_mode(a_pm), .run_enable(a_re), .load_timer(a_lt),
      .output_leds(a_leds), .timer_enabled_led(a_tel), .timer_on_led(a_tol), .any_done(a_ad)
   );

   multi_timer_control #(.NUM_CH(4), .CH_W(2), .LED_W(8), .ALARM_BLINKS(4), .AUTO_RELOAD(1))
   dut_b (
      .clk(clk), .reset(reset), .ch_sel(ch_sel), .cooktime_req(cooktime_req),
      .start_req(start_req), .pause_req(pause_req), .seconds_req(seconds_req),
      .minutes_req(minutes_req), .timer_en(timer_en), .blink_pulse(blink_pulse),
      .timer_done(timer_done), .bargraph(bargraph), .increment_seconds(b_is),
      .increment_minutes(b_im), .prog_mode(b_pm), .run_enable(b_re), .load_timer(b_lt),
      .output_leds(b_leds), .timer_enabled_led(b_tel), .timer_on_led(b_tol), .any_done(b_ad)
   );

   multi_timer_control #(.NUM_CH(3), .CH_W(2), .LED_W(8), .ALARM_BLINKS(16), .AUTO_RELOAD(0))
   dut_c (
      .clk(clk), .reset(reset), .ch_sel(ch_sel), .cooktime_req(cooktime_req),
      .start_req(start_req), .pause_req(pause_req), .seconds_req(seconds_req),
      .minutes_req(minutes_req), .timer_en(timer_en), .blink_pulse(blink_pulse),
      .timer_done(timer_done[2:0]), .bargraph(bargraph[23:0]), .increment_seconds(c_is),
      .increment_minutes(c_im), .prog_mode(c_pm), .run_enable(c_re), .load_timer(c_lt),
      .output_leds(c_leds), .timer_enabled_led(c_tel), .timer_on_led(c_tol), .any_done(c_ad)
   );

   function automatic int nch_of(input int k);
      return (k == 2) ? 3 : 4;
   endfunction

   function automatic bit ar_of(input int k);
      return (k == 1);
   endfunction

   function automatic int ab_of(input int k);
      return (k == 1) ? 4 : 16;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         for (int i = 0; i < 4; i++) begin
            m_st[k][i]  = M_IDLE;
            m_rem[k][i] = 0;
         end
      end
      m_flash = 1'b0;
   endtask

   // Alarm tracked as blinks remaining until reload rather than blinks elapsed.
   task automatic model_step();
      bit s, cook, st, ps;
      for (int k = 0; k < NI; k++) begin
         for (int i = 0; i < nch_of(k); i++) begin
            s    = (int'(ch_sel) == i);
            cook = s && cooktime_req;
            st   = s && start_req;
            ps   = s && pause_req;
            case (m_st[k][i])
               M_IDLE: if (cook) m_st[k][i] = M_PROG; else if (st) m_st[k][i] = M_LOAD;
               M_PROG: if (st && !cooktime_req) m_st[k][i] = M_LOAD;
               M_LOAD: m_st[k][i] = M_RUN;
               M_RUN: begin
                  if (cook) m_st[k][i] = M_PROG;
                  else if (timer_done[i]) begin
                     m_st[k][i]  = M_DONE;
                     m_rem[k][i] = ab_of(k);
                  end else if (ps) m_st[k][i] = M_PAUSE;
               end
               M_PAUSE: if (cook) m_st[k][i] = M_PROG; else if (ps || st) m_st[k][i] = M_RUN;
               M_DONE: begin
                  if (cook) m_st[k][i] = M_PROG;
                  else if (st) m_st[k][i] = M_LOAD;
                  else if (blink_pulse && m_rem[k][i] > 0) begin
                     if (ar_of(k) && m_rem[k][i] == 1) m_st[k][i] = M_LOAD;
                     else m_rem[k][i] = m_rem[k][i] - 1;
                  end
               end
               default: m_st[k][i] = M_IDLE;
            endcase
         end
      end
      m_flash = m_flash ^ blink_pulse;
   endtask

   task automatic check_inst(input int k, input string nm, input logic [7:0] pm,
                             input logic [7:0] re, input logic [7:0] lt, input logic [7:0] leds,
                             input logic is, input logic im, input logic tel, input logic tol,
                             input logic ad);
      logic [7:0] e_pm, e_re, e_lt, e_leds;
      logic       e_ad, e_prog, e_tel;
      int         s;
      e_pm = '0; e_re = '0; e_lt = '0; e_leds = '0; e_ad = 0; e_prog = 0; e_tel = 0;
      for (int i = 0; i < nch_of(k); i++) begin
         e_pm[i] = (m_st[k][i] == M_PROG);
         e_re[i] = (m_st[k][i] == M_RUN) && timer_en;
         e_lt[i] = (m_st[k][i] == M_LOAD);
         if (m_st[k][i] == M_DONE) e_ad = 1;
      end
      s = int'(ch_sel);
      if (s < nch_of(k)) begin
         e_prog = e_pm[s];
         e_tel  = e_re[s];
         if (m_st[k][s] == M_RUN) e_leds = bargraph[s*8 +: 8];
         else if (m_st[k][s] == M_PAUSE) e_leds = bargraph[s*8 +: 8] & {8{m_flash}};
         else if (m_st[k][s] == M_DONE) e_leds = {8{m_flash}};
      end
      chk({nm, ".prog_mode"}, pm, e_pm);
      chk({nm, ".run_enable"}, re, e_re);
      chk({nm, ".load_timer"}, lt, e_lt);
      chk({nm, ".output_leds"}, leds, e_leds);
      chk({nm, ".inc_sec"}, 8'(is), 8'(seconds_req & cooktime_req & e_prog));
      chk({nm, ".inc_min"}, 8'(im), 8'(minutes_req & cooktime_req & e_prog));
      chk({nm, ".en_led"}, 8'(tel), 8'(e_tel));
      chk({nm, ".on_led"}, 8'(tol), 8'(e_tel & m_flash));
      chk({nm, ".any_done"}, 8'(ad), 8'(e_ad));
   endtask

   // Inputs are set just after a falling edge; outputs checked 1 unit later.
   task automatic tick();
      if (reset) model_reset();
      #1;
      check_inst(0, "a", 8'(a_pm), 8'(a_re), 8'(a_lt), a_leds, a_is, a_im, a_tel, a_tol, a_ad);
      check_inst(1, "b", 8'(b_pm), 8'(b_re), 8'(b_lt), b_leds, b_is, b_im, b_tel, b_tol, b_ad);
      check_inst(2, "c", 8'(c_pm), 8'(c_re), 8'(c_lt), c_leds, c_is, c_im, c_tel, c_tol, c_ad);
      if (!reset) model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset = 1; ch_sel = 0; cooktime_req = 0; start_req = 0; pause_req = 0;
      seconds_req = 0; minutes_req = 0; timer_en = 1; blink_pulse = 0;
      timer_done = 0; bargraph = 0;
      model_reset();
      @(negedge clk);
      #1 chk("reset any_done", 8'(a_ad), 8'd0);
      chk("reset leds", a_leds, 8'h00);
      tick(); tick();
      reset = 0;
      tick();

      // Program channel 1, three seconds increments, then load and run.
      ch_sel = 1; cooktime_req = 1; tick();
      for (int n = 0; n < 3; n++) begin
         seconds_req = 1;
         #1 chk("tp1 inc_sec", 8'(a_is), 8'd1);
         tick();
         seconds_req = 0;
         tick();
      end
      #1 chk("tp1 prog_mode", 8'(a_pm), 8'b0010);
      cooktime_req = 0; start_req = 1; tick();
      start_req = 0;
      #1 chk("tp1 load strobe", 8'(a_lt), 8'b0010);
      tick();
      #1 chk("tp1 load gone", 8'(a_lt), 8'b0000);
      chk("tp1 run_enable", 8'(a_re), 8'b0010);

      // Channels 0 and 2 run, both finish together.
      ch_sel = 0; start_req = 1; tick(); start_req = 0; tick();
      ch_sel = 2; start_req = 1; tick(); start_req = 0; tick();
      bargraph = 32'h000F_0000;
      #1 chk("tp2 bargraph", a_leds, 8'h0F);
      timer_done = 4'b0101; tick(); timer_done = 0;
      #1 chk("tp2 any_done", 8'(a_ad), 8'd1);
      chk("tp2 run_enable", 8'(a_re), 8'b0010);
      blink_pulse = 1; tick(); blink_pulse = 0;
      #1 l1 = a_leds;
      tick();
      blink_pulse = 1; tick(); blink_pulse = 0;
      #1 l2 = a_leds;
      chk("tp2 flash on", l1, 8'hFF);
      chk("tp2 flash off", l2, 8'h00);

      // Channel 3 pause, ignored done, resume without reload.
      ch_sel = 3; start_req = 1; tick(); start_req = 0; tick();
      bargraph = 32'hA50F_0000;
      pause_req = 1; tick(); pause_req = 0;
      #1 chk("tp3 paused run_enable", 8'(a_re), 8'b0010);
      blink_pulse = 1; tick(); blink_pulse = 0;
      #1 chk("tp3 pause leds", a_leds, 8'hA5);
      timer_done = 4'b1000; tick(); timer_done = 0;
      #1 chk("tp3 done ignored", a_leds, 8'hA5);
      start_req = 1;
      #1 chk("tp3 no load pre", 8'(a_lt), 8'd0);
      tick(); start_req = 0;
      #1 chk("tp3 no load post", 8'(a_lt), 8'd0);
      chk("tp3 resumed", 8'(a_re), 8'b1010);

      // Channel 1 alarm: dut_b reloads after four blinks, dut_a stays in DONE.
      ch_sel = 1; timer_done = 4'b0010; tick(); timer_done = 0;
      for (int j = 1; j <= 4; j++) begin
         blink_pulse = 1; tick(); blink_pulse = 0;
         if (j == 1) begin
            #1 chk("tp4 reload ch0/2", 8'(b_lt), 8'b0101);
         end
         if (j == 4) begin
            #1 chk("tp4 reload ch1", 8'(b_lt), 8'b0010);
            chk("tp4 no reload a", 8'(a_lt), 8'd0);
         end
         if (j != 4) tick();
      end
      tick();
      #1 chk("tp4 b running", 8'(b_re), 8'b1111);
      chk("tp4 a state", 8'(a_re), 8'b1000);

      // cooktime_req beats timer_done in RUN; invalid channel select on dut_c.
      start_req = 1; tick(); start_req = 0; tick();
      cooktime_req = 1; timer_done = 4'b0010; tick(); timer_done = 0;
      #1 chk("tp5 a prog", 8'(a_pm), 8'b0010);
      chk("tp5 b prog", 8'(b_pm), 8'b0010);
      cooktime_req = 0;
      ch_sel = 3;
      #1 chk("tp5 c leds", c_leds, 8'h00);
      cooktime_req = 1; seconds_req = 1;
      #1 chk("tp5 c inc", 8'(c_is), 8'd0);
      tick();
      seconds_req = 0; cooktime_req = 0; start_req = 1; tick(); start_req = 0;
      #1 chk("tp5 c prog", 8'(c_pm), 8'b010);

      // Reset while ch0 loads and ch1 alarms.
      ch_sel = 1; start_req = 1; tick(); start_req = 0; tick();
      timer_done = 4'b0010; tick(); timer_done = 0;
      ch_sel = 0; start_req = 1; tick(); start_req = 0;
      #1 chk("tp6 ch0 loading", 8'(a_lt), 8'b0001);
      reset = 1;
      #1 chk("tp6 reset load", 8'(a_lt), 8'd0);
      chk("tp6 reset done", 8'(a_ad), 8'd0);
      tick();
      reset = 0; tick();
      #1 chk("tp6 no strobe", 8'(a_lt), 8'd0);

      for (int n = 0; n < 3000; n++) begin
         reset        = ($urandom_range(0, 399) == 0);
         ch_sel       = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 5) == 0) cooktime_req = ~cooktime_req;
         start_req    = ($urandom_range(0, 4) == 0);
         pause_req    = ($urandom_range(0, 5) == 0);
         seconds_req  = ($urandom_range(0, 1) == 1);
         minutes_req  = ($urandom_range(0, 1) == 1);
         timer_en     = ($urandom_range(0, 7) != 0);
         blink_pulse  = ($urandom_range(0, 3) == 0);
         timer_done   = 4'($urandom) & 4'($urandom) & 4'($urandom);
         bargraph     = $urandom;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/multi_timer_control.md
Name: multi_timer_control

Overview:
- Parametrised N-channel successor to the single egg-timer main controller.
- Holds one control FSM per countdown channel and routes the shared user controls to the channel picked by ch_sel.
- Drives the per-channel load and enable strobes.
- Multiplexes the selected channel's bargraph or alarm flash onto the shared LED bank; adds pause/resume and optional auto-reload after an alarm period.

Parameters:
NUM_CH, 4, number of independent countdown channels (1..8)
CH_W, 2, width of ch_sel; must satisfy 2**CH_W >= NUM_CH
LED_W, 8, width of each bargraph slice and of output_leds
ALARM_BLINKS, 16, blink_pulse count spent in DONE before auto-reload; 0 = alarm until user acts
AUTO_RELOAD, 0, 1 = DONE returns to LOAD after ALARM_BLINKS; 0 = stays in DONE

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
ch_sel  in  CH_W  channel targeted by user requests and shown on LEDs
cooktime_req  in  1  set-time mode request (level, debounced)
start_req  in  1  start pulse, 1 cycle
pause_req  in  1  pause/resume toggle pulse, 1 cycle
seconds_req  in  1  seconds increment request
minutes_req  in  1  minutes increment request
timer_en  in  1  global countdown enable switch
blink_pulse  in  1  1-cycle flash timing tick
timer_done  in  NUM_CH  per-channel countdown reached zero
bargraph  in  NUM_CH*LED_W  per-channel progress; channel i = bits [i*LED_W +: LED_W]
increment_seconds  out  1  seconds_req gated to a programming selected channel
increment_minutes  out  1  minutes_req gated likewise
prog_mode  out  NUM_CH  channel i in PROG
run_enable  out  NUM_CH  channel i counts down
load_timer  out  NUM_CH  1-cycle load strobe per channel
output_leds  out  LED_W  LED bank for selected channel
timer_enabled_led  out  1  run_enable[ch_sel]
timer_on_led  out  1  run_enable[ch_sel] & flash
any_done  out  1  OR over channels in DONE

Behaviour:
- flash register: reset 0; toggles on each blink_pulse. Shared by all channels.
- Per-channel FSM states: IDLE (reset), PROG, LOAD, RUN, PAUSE, DONE. sel_i = (ch_sel == i). ch_sel >= NUM_CH selects no channel.
- IDLE:
  - sel_i & cooktime_req -> PROG
  - else sel_i & start_req -> LOAD
- PROG: sel_i & start_req & !cooktime_req -> LOAD. Deselection leaves the channel in PROG.
- LOAD: unconditional -> RUN after exactly 1 cycle; load_timer[i] = 1 for that cycle only.
- RUN: priority order
  1. sel_i & cooktime_req -> PROG
  2. timer_done[i] -> DONE (independent of sel_i)
  3. sel_i & pause_req -> PAUSE
- PAUSE:
  1. sel_i & cooktime_req -> PROG
  2. sel_i & (pause_req | start_req) -> RUN; resumes without reload
  - timer_done is ignored in PAUSE.
- DONE:
  1. sel_i & cooktime_req -> PROG
  2. sel_i & start_req -> LOAD
  3. AUTO_RELOAD & ALARM_BLINKS != 0 & alarm counter == ALARM_BLINKS-1 & blink_pulse -> LOAD
- Alarm counter, per channel:
  - Width fits ALARM_BLINKS.
  - Cleared on entering DONE; increments on blink_pulse while in DONE; saturates.
- Outputs are combinational from registered state; all outputs are 0 during and immediately after reset.
  - prog_mode[i] = PROG.
  - run_enable[i] = RUN & timer_en.
  - increment_seconds = seconds_req & prog_mode[ch_sel] & cooktime_req; increment_minutes likewise.
- output_leds by selected channel state:
  - PROG, IDLE, LOAD, or invalid ch_sel: 0
  - RUN: bargraph slice
  - PAUSE: bargraph slice & {LED_W{flash}}
  - DONE: {LED_W{flash}}
- Simultaneous events:
  - Requests affect only the selected channel.
  - Several channels may take timer_done in the same cycle; each transitions independently.
  - Changing ch_sel mid-operation never changes any channel's state; the LED mux follows in the same cycle.
- Reset mid-operation: all channels to IDLE, flash and alarm counters cleared, no load strobe is emitted.

Test Plan:
- Reset, then ch_sel=1, cooktime_req=1, seconds_req pulse x3 -> prog_mode=4'b0010, increment_seconds pulses 3 times. Then release cooktime_req and pulse start_req -> load_timer=4'b0010 for exactly 1 cycle, then run_enable[1]=1 with timer_en=1.
- Ch0 and ch2 RUN, bargraph ch2=8'h0F, ch_sel=2 -> output_leds=8'h0F. Assert timer_done=4'b0101 -> both channels DONE, any_done=1, output_leds toggles 8'h00/8'hFF on blink_pulse.
- Ch3 RUN, pause_req -> run_enable[3]=0, LEDs blink the bargraph. timer_done[3] during PAUSE is ignored. start_req -> RUN with no load_timer strobe.
- AUTO_RELOAD=1, ALARM_BLINKS=4, ch1 DONE -> after the 4th blink_pulse, load_timer[1]=1 for 1 cycle, then RUN. Same case with AUTO_RELOAD=0 -> ch1 stays DONE.
- RUN with cooktime_req and timer_done asserted in the same cycle -> PROG. ch_sel=3 with NUM_CH=3 -> output_leds=0 and requests have no effect.
- Assert reset while ch0 is in LOAD and ch1 in DONE -> all outputs 0 immediately, with no load strobe after reset release.
